// File: rtl/shared_bus_arbiter.sv
// Round-robin arbiter that hands a shared output channel to one requester at a time.
// A grant lasts until last, MAX_BURST beats, or the owner drops req, then takes a one-cycle idle bubble.
module shared_bus_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           last,
    input  logic [NUM_REQ*DATA_W-1:0]    data_in,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    input  logic                         out_ready,
    output logic [$clog2(NUM_REQ)-1:0]   out_src,
    output logic                         busy
);
    localparam int SW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

    state_t                         state, state_nxt;
    logic   [SW-1:0]                rr_ptr;
    logic   [CW-1:0]                beat_cnt;
    logic   [NUM_REQ-1:0][DATA_W-1:0] lanes;
    logic   [SW-1:0]                pick;
    logic                           pick_vld;
    logic                           cur_req, cur_last, beat, release_x;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign lanes[g] = data_in[g*DATA_W +: DATA_W];
    end

    // Walk downward so the candidate closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        int s;
        s        = 0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            s = int'(rr_ptr) + i;
            if (s >= NUM_REQ) s = s - NUM_REQ;
            if (req[s]) begin
                pick     = SW'(s);
                pick_vld = 1'b1;
            end
        end
    end

    assign cur_req   = req[out_src];
    assign cur_last  = last[out_src];
    assign beat      = (state == XFER) && cur_req && out_ready;
    assign release_x = (state == XFER) &&
                       (!cur_req || (beat && (cur_last || beat_cnt == CW'(MAX_BURST - 1))));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            out_src  <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_vld) begin
                grant    <= NUM_REQ'(1) << pick;
                out_src  <= pick;
                rr_ptr   <= (pick == SW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
                beat_cnt <= '0;
            end else if (release_x) begin
                grant <= '0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld)  state_nxt = XFER;
            XFER:    if (release_x) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == XFER);
        out_valid = busy && cur_req;
        out_data  = out_valid ? lanes[out_src] : '0;
    end

endmodule
